// File: rtl/spmv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spmv_mem_arbiter
// Description : Round-robin arbiter that shares one PE memory port among N
//               requesters. Loads receive a free memory tag; responses are
//               steered back to the owning requester with its own tag.
// Revision    : 1.0 - initial release
// ============================================================================
module spmv_mem_arbiter #(
  parameter int N      = 4,
  parameter int UTAG_W = 4,
  parameter int NTAGS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_ld,
  input  logic [N-1:0]          req_st,
  input  logic [N*48-1:0]       req_addr,
  input  logic [N*64-1:0]       req_d_or_tag,
  output logic [N-1:0]          req_stall,
  output logic [N-1:0]          rsp_push,
  output logic [N*UTAG_W-1:0]   rsp_tag,
  output logic [N*64-1:0]       rsp_q,
  output logic                  req_mem_ld,
  output logic                  req_mem_st,
  output logic [47:0]           req_mem_addr,
  output logic [63:0]           req_mem_d_or_tag,
  input  logic                  req_mem_stall,
  input  logic                  rsp_mem_push,
  input  logic [$clog2(NTAGS)-1:0] rsp_mem_tag,
  input  logic [63:0]           rsp_mem_q,
  output logic                  rsp_mem_stall,
  output logic                  busy,
  output logic                  err
);

  localparam int IDW  = $clog2(N);
  localparam int TAGW = $clog2(NTAGS);
  localparam logic [IDW:0]   c_n_ext = (IDW+1)'(N);
  localparam logic [IDW-1:0] c_last  = IDW'(N-1);

  // Tag table: one entry per memory tag
  logic [NTAGS-1:0]  r_tag_busy;
  logic [IDW-1:0]    r_tag_owner [NTAGS];
  logic [UTAG_W-1:0] r_tag_utag  [NTAGS];

  logic [IDW-1:0]    r_rr;

  // Registered memory request stage
  logic              r_mem_ld;
  logic              r_mem_st;
  logic [47:0]       r_mem_addr;
  logic [63:0]       r_mem_d;

  // Registered response stage
  logic [N-1:0]        r_rsp_push;
  logic [N*UTAG_W-1:0] r_rsp_tag;
  logic [63:0]         r_rsp_q;
  logic                r_err;

  logic              w_free_any;
  logic [TAGW-1:0]   w_free_idx;
  logic [N-1:0]      w_elig;
  logic              w_gnt_vld;
  logic [IDW-1:0]    w_gnt_idx;
  logic [IDW:0]      w_rot_sum;
  logic [N-1:0]      w_gnt_oh;
  logic              w_sel_ld;
  logic              w_sel_st;
  logic [47:0]       w_sel_addr;
  logic [63:0]       w_sel_d;
  logic              w_rsp_hit;
  logic [IDW-1:0]    w_rsp_owner;
  logic [UTAG_W-1:0] w_rsp_utag;
  logic [N-1:0]      w_rsp_push_nxt;
  logic [N*UTAG_W-1:0] w_rsp_tag_nxt;

  // Lowest free tag, taken from registered table state only so a tag freed
  // this cycle is not handed out until the next one
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int t = NTAGS-1; t >= 0; t--) begin
      if (!r_tag_busy[t]) begin
        w_free_any = 1'b1;
        w_free_idx = TAGW'(t);
      end
    end
  end

  // A load needs a free tag; ld and st together is treated as a store
  assign w_elig = (req_ld | req_st) & (req_st | {N{w_free_any}});

  // Round-robin pick: first eligible requester at or after the pointer
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_rot_sum = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_rot_sum = {1'b0, r_rr} + (IDW+1)'(k);
      if (w_rot_sum >= c_n_ext) begin
        w_rot_sum = w_rot_sum - c_n_ext;
      end
      if (w_elig[w_rot_sum[IDW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_rot_sum[IDW-1:0];
      end
    end
    w_gnt_vld = w_gnt_vld & ~req_mem_stall & rst_n;
  end

  // Select the winner's request fields and build the one-hot grant
  always_comb begin
    w_sel_ld   = 1'b0;
    w_sel_st   = 1'b0;
    w_sel_addr = '0;
    w_sel_d    = '0;
    w_gnt_oh   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_sel_ld   = req_ld[i] & ~req_st[i];
        w_sel_st   = req_st[i];
        w_sel_addr = req_addr[i*48 +: 48];
        w_sel_d    = req_d_or_tag[i*64 +: 64];
        w_gnt_oh[i] = w_gnt_vld;
      end
    end
  end

  assign req_stall = ~w_gnt_oh;

  // Route a memory response to the owner of its tag
  always_comb begin
    w_rsp_hit      = rsp_mem_push & r_tag_busy[rsp_mem_tag];
    w_rsp_owner    = r_tag_owner[rsp_mem_tag];
    w_rsp_utag     = r_tag_utag[rsp_mem_tag];
    w_rsp_push_nxt = '0;
    w_rsp_tag_nxt  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_rsp_hit && (w_rsp_owner == IDW'(i))) begin
        w_rsp_push_nxt[i] = 1'b1;
        w_rsp_tag_nxt[i*UTAG_W +: UTAG_W] = w_rsp_utag;
      end
    end
  end

  // Request stage, tag table, response stage and error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_busy <= '0;
      for (int t = 0; t < NTAGS; t++) begin
        r_tag_owner[t] <= '0;
        r_tag_utag[t]  <= '0;
      end
      r_rr       <= '0;
      r_mem_ld   <= 1'b0;
      r_mem_st   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_d    <= '0;
      r_rsp_push <= '0;
      r_rsp_tag  <= '0;
      r_rsp_q    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_mem_ld   <= w_gnt_vld & w_sel_ld;
      r_mem_st   <= w_gnt_vld & w_sel_st;
      r_rsp_push <= w_rsp_push_nxt;
      r_rsp_tag  <= w_rsp_tag_nxt;

      if (w_rsp_hit) begin
        r_tag_busy[rsp_mem_tag] <= 1'b0;
        r_rsp_q                 <= rsp_mem_q;
      end else if (rsp_mem_push) begin
        r_err <= 1'b1;
      end

      if (w_gnt_vld) begin
        r_rr       <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
        r_mem_addr <= w_sel_addr;
        if (w_sel_ld) begin
          // Allocated tag index never equals the one being freed: it was
          // already free in the registered table
          r_tag_busy[w_free_idx]  <= 1'b1;
          r_tag_owner[w_free_idx] <= w_gnt_idx;
          r_tag_utag[w_free_idx]  <= w_sel_d[UTAG_W-1:0];
          r_mem_d                 <= 64'(w_free_idx);
        end else begin
          r_mem_d <= w_sel_d;
        end
      end
    end
  end

  assign req_mem_ld       = r_mem_ld;
  assign req_mem_st       = r_mem_st;
  assign req_mem_addr     = r_mem_addr;
  assign req_mem_d_or_tag = r_mem_d;
  assign rsp_push         = r_rsp_push;
  assign rsp_tag          = r_rsp_tag;
  assign rsp_q            = {N{r_rsp_q}};
  assign rsp_mem_stall    = 1'b0;
  assign err              = r_err;
  assign busy             = (|r_tag_busy) | r_mem_ld | r_mem_st | (|r_rsp_push);

endmodule
`default_nettype wire

// File: tb/tb_spmv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spmv_mem_arbiter
// Description : Directed, table-driven self-checking bench for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spmv_mem_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    ld, st;
  logic [47:0]   avals [4];
  logic [63:0]   dvals [4];
  logic [191:0]  req_addr;
  logic [255:0]  req_d_or_tag;
  logic [3:0]    req_stall, rsp_push;
  logic [15:0]   rsp_tag;
  logic [255:0]  rsp_q;
  logic          req_mem_ld, req_mem_st, req_mem_stall, rsp_mem_push;
  logic [47:0]   req_mem_addr;
  logic [63:0]   req_mem_d_or_tag, rsp_mem_q;
  logic [2:0]    rsp_mem_tag;
  logic          rsp_mem_stall, busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign req_addr     = {avals[3], avals[2], avals[1], avals[0]};
  assign req_d_or_tag = {dvals[3], dvals[2], dvals[1], dvals[0]};

  spmv_mem_arbiter #(.N(4), .UTAG_W(4), .NTAGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_ld(ld), .req_st(st),
    .req_addr(req_addr), .req_d_or_tag(req_d_or_tag),
    .req_stall(req_stall), .rsp_push(rsp_push), .rsp_tag(rsp_tag), .rsp_q(rsp_q),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .rsp_mem_stall(rsp_mem_stall), .busy(busy), .err(err)
  );

  typedef struct {
    logic [3:0]  ld, st;
    logic        mstall, rpush;
    logic [2:0]  rtag;
    logic [63:0] rq;
    logic [3:0]  e_stall;
    logic        e_ld, e_st;
    logic [2:0]  e_mtag;
    logic [47:0] e_addr;
    logic [3:0]  e_push;
    logic [15:0] e_rtag;
    logic        e_err, e_busy;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(
    input logic [3:0] l, input logic [3:0] s, input logic ms, input logic rp,
    input logic [2:0] rt, input logic [63:0] q, input logic [3:0] es,
    input logic el, input logic est, input logic [2:0] emt, input logic [47:0] ea,
    input logic [3:0] ep, input logic [15:0] ert, input logic ee, input logic eb);
    vec_t v;
    v.ld = l; v.st = s; v.mstall = ms; v.rpush = rp; v.rtag = rt; v.rq = q;
    v.e_stall = es; v.e_ld = el; v.e_st = est; v.e_mtag = emt; v.e_addr = ea;
    v.e_push = ep; v.e_rtag = ert; v.e_err = ee; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] l, input logic [3:0] s, input logic ms,
                       input logic rp, input logic [2:0] rt, input logic [63:0] q);
    ld = l; st = s; req_mem_stall = ms;
    rsp_mem_push = rp; rsp_mem_tag = rt; rsp_mem_q = q;
  endtask

  task automatic idle();
    drive(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 64'h0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ld = 4'hF;
    #1 chk("rst_stall", 64'(req_stall), 64'hF);
    tick();
    chk("rst_outs", {req_mem_ld, req_mem_st, busy, err, rsp_mem_stall, rsp_push},
        64'h0);
    to_negedge();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      avals[i] = 48'(48'h80 * (i + 1));
      dvals[i] = 64'h3FF0000000000000 | 64'(i + 4);
    end

    //      ld    st   ms   rp  rt    rq        stall ld st mt  addr     push  rtag    err bsy
    tbl[0]  = mk(4'h2, 4'h0, 0, 0, 3'd0, 64'h0,    4'hD, 1, 0, 0, 48'h100, 4'h0, 16'h0000, 0, 1);
    tbl[1]  = mk(4'h0, 4'h0, 0, 1, 3'd0, 64'hDEAD, 4'hF, 0, 0, 0, 48'h0,   4'h2, 16'h0050, 0, 1);
    tbl[2]  = mk(4'h0, 4'h0, 0, 0, 3'd0, 64'h0,    4'hF, 0, 0, 0, 48'h0,   4'h0, 16'h0000, 0, 0);
    tbl[3]  = mk(4'hF, 4'h0, 0, 0, 3'd0, 64'h0,    4'hB, 1, 0, 0, 48'h180, 4'h0, 16'h0000, 0, 1);
    tbl[4]  = mk(4'hF, 4'h0, 0, 0, 3'd0, 64'h0,    4'h7, 1, 0, 1, 48'h200, 4'h0, 16'h0000, 0, 1);
    tbl[5]  = mk(4'hF, 4'h0, 0, 0, 3'd0, 64'h0,    4'hE, 1, 0, 2, 48'h080, 4'h0, 16'h0000, 0, 1);
    tbl[6]  = mk(4'hF, 4'h0, 0, 0, 3'd0, 64'h0,    4'hD, 1, 0, 3, 48'h100, 4'h0, 16'h0000, 0, 1);
    tbl[7]  = mk(4'h4, 4'h1, 1, 0, 3'd0, 64'h0,    4'hF, 0, 0, 0, 48'h0,   4'h0, 16'h0000, 0, 1);
    tbl[8]  = mk(4'h4, 4'h1, 0, 0, 3'd0, 64'h0,    4'hB, 1, 0, 4, 48'h180, 4'h0, 16'h0000, 0, 1);
    tbl[9]  = mk(4'h0, 4'h1, 0, 0, 3'd0, 64'h0,    4'hE, 0, 1, 0, 48'h080, 4'h0, 16'h0000, 0, 1);
    tbl[10] = mk(4'h3, 4'h3, 0, 0, 3'd0, 64'h0,    4'hD, 0, 1, 0, 48'h100, 4'h0, 16'h0000, 0, 1);
    tbl[11] = mk(4'h0, 4'h0, 0, 1, 3'd2, 64'hBEEF, 4'hF, 0, 0, 0, 48'h0,   4'h1, 16'h0004, 0, 1);
    tbl[12] = mk(4'h0, 4'h0, 0, 1, 3'd7, 64'h0,    4'hF, 0, 0, 0, 48'h0,   4'h0, 16'h0000, 1, 1);
    tbl[13] = mk(4'h0, 4'h0, 0, 1, 3'd0, 64'hCAFE, 4'hF, 0, 0, 0, 48'h0,   4'h4, 16'h0600, 1, 1);

    // Power-on reset with requests asserted
    to_negedge();
    do_reset();

    // Table: single load/response, rotation, stall, stores, ld+st, err
    for (int v = 0; v < 14; v++) begin
      drive(tbl[v].ld, tbl[v].st, tbl[v].mstall, tbl[v].rpush, tbl[v].rtag, tbl[v].rq);
      #1 chk($sformatf("v%0d_stall", v), 64'(req_stall), 64'(tbl[v].e_stall));
      tick();
      chk($sformatf("v%0d_ld", v), 64'(req_mem_ld), 64'(tbl[v].e_ld));
      chk($sformatf("v%0d_st", v), 64'(req_mem_st), 64'(tbl[v].e_st));
      if (tbl[v].e_ld) chk($sformatf("v%0d_mtag", v), req_mem_d_or_tag, 64'(tbl[v].e_mtag));
      if (tbl[v].e_ld || tbl[v].e_st) chk($sformatf("v%0d_addr", v), 64'(req_mem_addr), 64'(tbl[v].e_addr));
      chk($sformatf("v%0d_push", v), 64'(rsp_push), 64'(tbl[v].e_push));
      chk($sformatf("v%0d_rtag", v), 64'(rsp_tag), 64'(tbl[v].e_rtag));
      if (tbl[v].e_push != 4'h0) begin
        chk($sformatf("v%0d_q0", v), rsp_q[63:0], tbl[v].rq);
        chk($sformatf("v%0d_q3", v), rsp_q[255:192], tbl[v].rq);
      end
      chk($sformatf("v%0d_err", v), 64'(err), 64'(tbl[v].e_err));
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'(tbl[v].e_busy));
      to_negedge();
    end

    // Tag exhaustion: requester 0 loads until all 8 tags are taken
    do_reset();
    for (int k = 0; k < 8; k++) begin
      avals[0] = 48'(48'h1000 + k);
      drive(4'h1, 4'h0, 0, 0, 3'd0, 64'h0);
      #1 chk($sformatf("ex%0d_stall", k), 64'(req_stall), 64'hE);
      tick();
      chk($sformatf("ex%0d_ld", k), 64'(req_mem_ld), 64'h1);
      chk($sformatf("ex%0d_tag", k), req_mem_d_or_tag, 64'(k));
      chk($sformatf("ex%0d_addr", k), 64'(req_mem_addr), 64'(48'h1000 + k));
      to_negedge();
    end
    // Ninth load stalls, but a store from requester 1 still goes through
    drive(4'h1, 4'h2, 0, 0, 3'd0, 64'h0);
    #1 chk("ex_full_stall", 64'(req_stall), 64'hD);
    tick();
    chk("ex_full_st", 64'({req_mem_ld, req_mem_st}), 64'h1);
    to_negedge();
    // Return tag 3: freed this cycle but not reusable until the next
    drive(4'h1, 4'h0, 0, 1, 3'd3, 64'h33);
    #1 chk("ex_free_stall", 64'(req_stall), 64'hF);
    tick();
    chk("ex_free_push", 64'(rsp_push), 64'h1);
    chk("ex_free_ld", 64'(req_mem_ld), 64'h0);
    to_negedge();
    drive(4'h1, 4'h0, 0, 0, 3'd0, 64'h0);
    #1 chk("ex_re_stall", 64'(req_stall), 64'hE);
    tick();
    chk("ex_re_ld", 64'(req_mem_ld), 64'h1);
    chk("ex_re_tag", req_mem_d_or_tag, 64'h3);
    to_negedge();

    // Out-of-order return: requesters 0,1,2 get tags 0,1,2; return 2,0,1
    avals[0] = 48'h80;
    do_reset();
    drive(4'h7, 4'h0, 0, 0, 3'd0, 64'h0); tick(); to_negedge();
    drive(4'h6, 4'h0, 0, 0, 3'd0, 64'h0); tick(); to_negedge();
    drive(4'h4, 4'h0, 0, 0, 3'd0, 64'h0); tick();
    chk("ooo_tag2", req_mem_d_or_tag, 64'h2);
    to_negedge();
    drive(4'h0, 4'h0, 0, 1, 3'd2, 64'hA2); tick();
    chk("ooo_p2", {48'(rsp_push), rsp_tag}, {48'h4, 16'h0600});
    to_negedge();
    drive(4'h0, 4'h0, 0, 1, 3'd0, 64'hA0); tick();
    chk("ooo_p0", {48'(rsp_push), rsp_tag}, {48'h1, 16'h0004});
    chk("ooo_q0", rsp_q[63:0], 64'hA0);
    to_negedge();
    drive(4'h0, 4'h0, 0, 1, 3'd1, 64'hA1); tick();
    chk("ooo_p1", {48'(rsp_push), rsp_tag}, {48'h2, 16'h0050});
    chk("ooo_busy_last", 64'(busy), 64'h1);
    to_negedge();
    idle(); tick();
    chk("ooo_busy_idle", 64'(busy), 64'h0);
    to_negedge();

    // Backpressure: store from requester 3 held off for 10 cycles
    dvals[3] = 64'h3FF0000000000000;
    for (int c = 0; c < 10; c++) begin
      drive(4'h0, 4'h8, 1, 0, 3'd0, 64'h0);
      #1 chk($sformatf("bp%0d_stall", c), 64'(req_stall), 64'hF);
      tick();
      chk($sformatf("bp%0d_st", c), 64'(req_mem_st), 64'h0);
      to_negedge();
    end
    drive(4'h0, 4'h8, 0, 0, 3'd0, 64'h0);
    #1 chk("bp_rel_stall", 64'(req_stall), 64'h7);
    tick();
    chk("bp_rel_st", 64'(req_mem_st), 64'h1);
    chk("bp_rel_data", req_mem_d_or_tag, 64'h3FF0000000000000);
    chk("bp_rel_addr", 64'(req_mem_addr), 64'h200);
    to_negedge();
    drive(4'h1, 4'h0, 0, 0, 3'd0, 64'h0); tick();
    chk("bp_notag", req_mem_d_or_tag, 64'h0);
    to_negedge();

    // Mid-operation reset with tags outstanding, then a stale response
    do_reset();
    drive(4'h1, 4'h0, 0, 0, 3'd0, 64'h0); tick(); to_negedge();
    drive(4'h2, 4'h0, 0, 0, 3'd0, 64'h0); tick();
    chk("rr_tag1", req_mem_d_or_tag, 64'h1);
    to_negedge();
    idle(); tick();
    chk("rr_busy_pre", 64'(busy), 64'h1);
    to_negedge();
    do_reset();
    drive(4'h0, 4'h0, 0, 1, 3'd0, 64'h77); tick();
    chk("rr_stale_push", 64'(rsp_push), 64'h0);
    chk("rr_stale_err", 64'(err), 64'h1);
    to_negedge();
    idle(); tick(); tick();
    chk("rr_err_sticky", 64'(err), 64'h1);
    to_negedge();
    do_reset();
    chk("rr_err_clr", 64'(err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spmv_mem_arbiter.md
Name: spmv_mem_arbiter

Overview:
- Shares the single PE memory port among N internal requesters: code/argument stream fetchers, x-vector loader and y-vector store unit.
- Round-robin arbitration onto one req_mem port.
- Each load gets a free 3-bit memory tag. Returning responses are routed to the owning requester with that requester's own tag restored.
- Sits between the PE stream units and the external req_mem/rsp_mem interface.

Parameters:
- N, 4, number of requesters (2..8).
- UTAG_W, 4, width of each requester's private load tag.
- NTAGS, 8, memory tags available; equals 2^width of rsp_mem_tag (3 bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_ld  in  N  per-requester load request.
- req_st  in  N  per-requester store request.
- req_addr  in  N*48  per-requester byte address; slice i is [48i+47:48i].
- req_d_or_tag  in  N*64  store data, or requester tag in bits [UTAG_W-1:0] for loads.
- req_stall  out  N  request not accepted this cycle.
- rsp_push  out  N  response valid for requester i.
- rsp_tag  out  N*UTAG_W  restored requester tag.
- rsp_q  out  N*64  response data (same value broadcast to all slices).
- req_mem_ld  out  1  memory load.
- req_mem_st  out  1  memory store.
- req_mem_addr  out  48  memory address.
- req_mem_d_or_tag  out  64  store data, or allocated memory tag (zero-extended) for loads.
- req_mem_stall  in  1  memory almost-full.
- rsp_mem_push  in  1  memory response valid.
- rsp_mem_tag  in  3  memory response tag.
- rsp_mem_q  in  64  memory response data.
- rsp_mem_stall  out  1  tied 0; responses are always accepted.
- busy  out  1  any tag outstanding or output stage valid.
- err  out  1  sticky: response received on an unallocated tag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs 0 except req_stall, which is all-ones.
  - Tag table all free.
  - Round-robin pointer 0.
  - err cleared.
- Requests are ignored during reset.
- Mid-operation reset discards all outstanding tags. A later response to a discarded tag sets err and is dropped.
- Eligibility: requester i is eligible if (req_ld[i] | req_st[i]). A load additionally requires at least one free tag. req_ld and req_st both high is treated as a store.
- Grant:
  - Among eligible requesters, pick the first at or after the rr pointer (i, i+1, ..., wrapping at N).
  - A grant happens only when req_mem_stall=0.
  - On grant, rr pointer <= winner+1 mod N.
- req_stall[i] is combinational: 0 only for the granted requester, 1 otherwise. A requester holds its request until it sees stall=0.
- Issue latency: an accepted request appears on req_mem_* exactly one cycle later, registered.
  - req_mem_ld/st pulse for one cycle per accepted request.
  - Memory tolerates one further request after raising stall.
- Tag allocation:
  - Use the lowest free index, computed from registered table state.
  - Store {owner id, utag} and mark the tag busy at the grant edge.
  - Stores allocate no tag.
- Response path:
  - rsp_mem_push with tag t at edge k gives rsp_push[owner]=1, rsp_tag slice = stored utag, rsp_q = data at edge k+1.
  - Tag t is freed at edge k and is allocatable from cycle k+1.
  - Response on a free tag: nothing pushed, err <= 1.
- A response and a grant in the same cycle proceed independently. The freed tag is not reused in that same cycle.
- All 8 tags busy: loads stall, stores still granted.
- busy = |tag_busy | req_mem_ld | req_mem_st | any rsp_push.

Test Plan:
- Single load: requester 1 load, addr 0x100, utag 5 → next cycle req_mem_ld=1, addr 0x100, d_or_tag=0. Mem response tag 0, q=0xDEAD → next cycle rsp_push=4'b0010, rsp_tag[1]=5, q=0xDEAD.
- Fairness: all 4 requesters load continuously, fixed 20-cycle memory latency → grants rotate 0,1,2,3,0,...; no requester waits more than 3 grants while tags are free.
- Tag exhaustion: 9 back-to-back loads, responses withheld → 8 issued with tags 0..7, 9th stalled. Return tag 3 → 9th issues next cycle with tag 3.
- Out-of-order return: tags returned 2,0,1 → each routed to the correct owner with its utag; busy falls to 0 after the last response.
- Backpressure and stores: req_mem_stall=1 for 10 cycles with a store pending → no grant, all req_stall=1. On release the store issues with data 0x3FF0000000000000 and consumes no tag.
- Reset/err: reset with 2 tags outstanding, then a response on tag 0 → no rsp_push, err=1 until next reset.
